// File: rtl/quad_encoder_slave_pkg.sv
// Shared types and constants for the quadrature encoder bus slave.
// Optional index channel is enabled with the QUAD_INDEX_EN macro.
package quad_encoder_slave_pkg;

  typedef enum logic [2:0] {
    QE_CONTROL  = 3'd0,
    QE_COUNT    = 3'd1,
    QE_VELOCITY = 3'd2,
    QE_STATUS   = 3'd3,
    QE_INDEX    = 3'd4
  } qe_reg_t;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_INV    = 2;
  localparam int CTRL_IDXCLR = 3;

  localparam int ST_A   = 0;
  localparam int ST_B   = 1;
  localparam int ST_DIR = 2;
  localparam int ST_ERR = 3;
  localparam int ST_IDX = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } bus_fsm_state_t;

  localparam logic READ_CMD  = 1'b0;
  localparam logic WRITE_CMD = 1'b1;

  // Gray {A,B} to position 0..3 along the forward sequence
  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/input_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter.
// Used for each encoder phase of quad_encoder_slave.
module input_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;
  logic [3:0] cnt_q, cnt_d;
  logic       lvl_q, lvl_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

  // cnt_q counts consecutive samples that differ from the accepted level
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q + 4'd1 >= 4'(FILTER_LEN)) begin
        lvl_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  assign q_o = lvl_q;

endmodule

// File: rtl/quad_encoder_slave.sv
// Quadrature encoder decoder with IO_bus register slave.
// Define QUAD_INDEX_EN to add the enc_z index channel and INDEX register.
module quad_encoder_slave
  import quad_encoder_slave_pkg::*;
#(
  parameter logic [7:0]  REG_BASE   = 8'd8,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned VEL_PERIOD = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        handshake1_1,
  output tri logic    handshake1_2,
  input  logic        RW,
  input  logic [7:0]  reg_address,
  input  logic [31:0] data_out,
  output tri logic [31:0] data_in,
  input  logic        enc_a,
`ifdef QUAD_INDEX_EN
  input  logic        enc_z,
`endif
  input  logic        enc_b
);

  localparam logic [7:0]  REG_LAST = REG_BASE + 8'd4;
  localparam logic [31:0] PER_LAST = 32'(VEL_PERIOD - 1);
`ifdef QUAD_INDEX_EN
  localparam logic [3:0]  CTRL_MASK = 4'b1101;
`else
  localparam logic [3:0]  CTRL_MASK = 4'b0101;
`endif

  bus_fsm_state_t state_q, state_d;
  logic        hs_q;
  logic [31:0] rdata_q, rdata;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] last_q, last_d;
  logic [31:0] vel_q, vel_d;
  logic [31:0] per_q, per_d;
  logic [1:0]  ab_q;
  logic        dir_q, dir_d;
  logic        err_q, err_d;

  logic        a_f, b_f;
  logic [1:0]  ab, chg;
  logic        in_range, access, wr, rd;
  logic [2:0]  off;
  logic        wr_ctrl, wr_count, st_rd, clear;
  logic        step, illegal, up, wrap;
  logic        idx_evt, idx_flag, idx_clr;
  logic [31:0] index_v;

  input_filter #(.FILTER_LEN(FILTER_LEN)) u_fa (
    .clk(clk), .reset(reset), .d_i(enc_a), .q_o(a_f)
  );
  input_filter #(.FILTER_LEN(FILTER_LEN)) u_fb (
    .clk(clk), .reset(reset), .d_i(enc_b), .q_o(b_f)
  );

  assign in_range = (reg_address >= REG_BASE) && (reg_address <= REG_LAST);
  assign off      = 3'(reg_address - REG_BASE);
  assign access   = (state_q == S_ACCESS) && in_range;
  assign wr       = access && (RW == WRITE_CMD);
  assign rd       = access && (RW == READ_CMD);
  assign wr_ctrl  = wr && (off == QE_CONTROL);
  assign wr_count = wr && (off == QE_COUNT);
  assign st_rd    = rd && (off == QE_STATUS);
  assign clear    = wr_ctrl && data_out[CTRL_CLR];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (handshake1_1 && in_range) state_d = S_ACCESS;
      S_ACCESS: state_d = S_ACK;
      S_ACK:    if (!handshake1_1) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign ab      = {a_f, b_f};
  assign chg     = ab ^ ab_q;
  assign step    = ctrl_q[CTRL_EN] && (chg == 2'b01 || chg == 2'b10);
  assign illegal = ctrl_q[CTRL_EN] && (chg == 2'b11);
  assign up      = ((gray2bin(ab) - gray2bin(ab_q)) == 2'd1) ^ ctrl_q[CTRL_INV];
  assign wrap    = (per_q == PER_LAST);
  assign idx_clr = idx_evt && ctrl_q[CTRL_IDXCLR];

`ifdef QUAD_INDEX_EN
  logic        z_f, z_q, idxf_q;
  logic [31:0] index_q;

  input_filter #(.FILTER_LEN(FILTER_LEN)) u_fz (
    .clk(clk), .reset(reset), .d_i(enc_z), .q_o(z_f)
  );

  assign idx_evt  = z_f && !z_q;
  assign idx_flag = idxf_q;
  assign index_v  = index_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_q     <= 1'b0;
      idxf_q  <= 1'b0;
      index_q <= '0;
    end else begin
      z_q    <= z_f;
      idxf_q <= (idxf_q && !st_rd) || idx_evt;
      if (idx_evt) index_q <= count_q;
    end
  end
`else
  assign idx_evt  = 1'b0;
  assign idx_flag = 1'b0;
  assign index_v  = '0;
`endif

  // Priority: CONTROL clear > index clear > COUNT write > encoder step
  always_comb begin
    count_d = count_q;
    last_d  = last_q;
    vel_d   = vel_q;
    ctrl_d  = ctrl_q;
    dir_d   = dir_q;
    per_d   = wrap ? '0 : per_q + 32'd1;
    err_d   = (err_q && !st_rd) || illegal;
    if (wr_ctrl) ctrl_d = data_out[3:0] & CTRL_MASK;
    if (step) dir_d = up;
    if (wrap) begin
      vel_d  = count_q - last_q;
      last_d = count_q;
    end
    if (clear) begin
      count_d = '0;
      last_d  = '0;
    end else if (idx_clr) begin
      count_d = '0;
    end else if (wr_count) begin
      count_d = data_out;
    end else if (step) begin
      count_d = up ? count_q + 32'd1 : count_q - 32'd1;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      off == QE_CONTROL:  rdata[3:0] = ctrl_q;
      off == QE_COUNT:    rdata = count_q;
      off == QE_VELOCITY: rdata = vel_q;
      off == QE_STATUS: begin
        rdata[ST_A]   = a_f;
        rdata[ST_B]   = b_f;
        rdata[ST_DIR] = dir_q;
        rdata[ST_ERR] = err_q;
        rdata[ST_IDX] = idx_flag;
      end
      off == QE_INDEX:    rdata = index_v;
      default:            rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hs_q    <= 1'b0;
      rdata_q <= '0;
      ctrl_q  <= '0;
      count_q <= '0;
      last_q  <= '0;
      vel_q   <= '0;
      per_q   <= '0;
      ab_q    <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_q    <= (state_q == S_ACK);
      if (rd) rdata_q <= rdata;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      last_q  <= last_d;
      vel_q   <= vel_d;
      per_q   <= per_d;
      ab_q    <= ab;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign handshake1_2 = hs_q ? 1'b1 : 1'bz;
  assign data_in      = hs_q ? rdata_q : 32'hz;

endmodule

// File: tb/tb_quad_encoder_slave.sv
// Directed bench for quad_encoder_slave: register table plus
// encoder sequences (steps, glitch, illegal, velocity, coincident clear).
module tb_quad_encoder_slave;

  localparam int FL = 4;
  localparam int VP = 2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hs1 = 1'b0;
  wire         hs2;
  logic        rw = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdat = '0;
  wire  [31:0] rdat;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
`ifdef QUAD_INDEX_EN
  logic        enc_z = 1'b0;
`endif

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int pos = 0;
  logic mdir = 1'b0;
  logic [1:0] gtab [4];

  quad_encoder_slave #(
    .REG_BASE(8'd8), .FILTER_LEN(FL), .VEL_PERIOD(VP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .handshake1_1(hs1),
    .handshake1_2(hs2),
    .RW(rw),
    .reg_address(addr),
    .data_out(wdat),
    .data_in(rdat),
    .enc_a(enc_a),
`ifdef QUAD_INDEX_EN
    .enc_z(enc_z),
`endif
    .enc_b(enc_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the bus is released
  task automatic bus(input logic r, input logic [7:0] a,
                     input logic [31:0] wd, output logic [31:0] rd,
                     output int lat);
    rd = '0;
    lat = -1;
    hs1 = 1'b1; rw = r; addr = a; wdat = wd;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (hs2 === 1'b1) begin
        lat = n - 1;
        rd = rdat;
        break;
      end
    end
    hs1 = 1'b0;
    if (lat < 0) begin
      tests++; failed++;
      $display("FAIL ack_timeout: addr %h got no ack required ack", a);
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (hs2 !== 1'b1) break;
    end
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
    int l;
    bus(1'b0, a, 32'h0, d, l);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    int l;
    logic [31:0] x;
    bus(1'b1, a, d, x, l);
  endtask

  task automatic set_enc();
    enc_a = gtab[pos][1];
    enc_b = gtab[pos][0];
  endtask

  task automatic step(input logic fwd);
    pos = fwd ? (pos + 1) % 4 : (pos + 3) % 4;
    mdir = fwd;
    set_enc();
    repeat (FL + 4) @(negedge clk);
  endtask

  task automatic wait_wrap();
    do @(negedge clk); while (cyc % VP != 0);
  endtask

  logic [31:0] d, exp;
  int lat;
  logic seen;

  initial begin
    gtab[0] = 2'b00; gtab[1] = 2'b01; gtab[2] = 2'b11; gtab[3] = 2'b10;

    vt[0]  = '{1'b0, 8'd9,  32'h0,    32'h0,    "rst_count"};
    vt[1]  = '{1'b0, 8'd8,  32'h0,    32'h0,    "rst_ctrl"};
    vt[2]  = '{1'b0, 8'd10, 32'h0,    32'h0,    "rst_vel"};
    vt[3]  = '{1'b0, 8'd11, 32'h0,    32'h0,    "rst_status"};
    vt[4]  = '{1'b0, 8'd12, 32'h0,    32'h0,    "rst_index"};
    vt[5]  = '{1'b1, 8'd8,  32'hF,    32'h0,    "wr_ctrl"};
`ifdef QUAD_INDEX_EN
    vt[6]  = '{1'b0, 8'd8,  32'h0,    32'hD,    "ctrl_mask"};
`else
    vt[6]  = '{1'b0, 8'd8,  32'h0,    32'h5,    "ctrl_mask"};
`endif
    vt[7]  = '{1'b1, 8'd10, 32'h55,   32'h0,    "wr_vel"};
    vt[8]  = '{1'b0, 8'd10, 32'h0,    32'h0,    "vel_ro"};
    vt[9]  = '{1'b1, 8'd9,  32'h1234, 32'h0,    "wr_count"};
    vt[10] = '{1'b0, 8'd9,  32'h0,    32'h1234, "count_preset"};
    vt[11] = '{1'b1, 8'd8,  32'h2,    32'h0,    "wr_clear"};
    vt[12] = '{1'b0, 8'd9,  32'h0,    32'h0,    "count_cleared"};
    vt[13] = '{1'b0, 8'd8,  32'h0,    32'h0,    "ctrl_after_clr"};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    bus(1'b0, 8'd9, 32'h0, d, lat);
    chk("ack_latency", 32'(lat), 32'd2);
    chk("first_read", d, 32'h0);
    chk("released", {31'b0, hs2 === 1'b1}, 32'h0);

    foreach (vt[i]) begin
      bus(vt[i].rw, vt[i].addr, vt[i].wdata, d, lat);
      if (vt[i].rw == 1'b0) chk(vt[i].name, d, vt[i].exp);
    end

    hs1 = 1'b1; addr = 8'd13; rw = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (hs2 === 1'b1) seen = 1'b1;
    end
    hs1 = 1'b0;
    chk("out_of_range", {31'b0, seen}, 32'h0);

    wr_reg(8'd8, 32'h1);
    repeat (8) step(1'b1);
    rd_reg(8'd9, d); chk("fwd8", d, 32'd8);
    repeat (10) step(1'b0);
    rd_reg(8'd9, d); chk("rev10", d, 32'hFFFFFFFE);

    wr_reg(8'd9, 32'hFFFFFFFF);
    step(1'b1);
    rd_reg(8'd9, d); chk("wrap_up", d, 32'h0);

    enc_a = ~enc_a;
    repeat (FL - 2) @(negedge clk);
    enc_a = ~enc_a;
    repeat (10) @(negedge clk);
    rd_reg(8'd9, d); chk("glitch", d, 32'h0);

    pos = (pos + 2) % 4;
    set_enc();
    repeat (FL + 4) @(negedge clk);
    rd_reg(8'd9, d); chk("illegal_count", d, 32'h0);
    exp = {28'h0, 1'b1, mdir, gtab[pos][0], gtab[pos][1]};
    rd_reg(8'd11, d); chk("status_err", d, exp);
    exp[3] = 1'b0;
    rd_reg(8'd11, d); chk("status_clr", d, exp);

    wait_wrap();
    repeat (100) step(1'b1);
    wait_wrap();
    rd_reg(8'd10, d); chk("vel_up100", d, 32'd100);
    repeat (30) step(1'b0);
    wait_wrap();
    rd_reg(8'd10, d); chk("vel_dn30", d, 32'hFFFFFFE2);
    rd_reg(8'd9, d); chk("count70", d, 32'd70);

    // Encoder step lands on the same edge as the CONTROL write
    pos = (pos + 1) % 4;
    set_enc();
    repeat (5) @(negedge clk);
    wr_reg(8'd8, 32'h3);
    repeat (FL + 4) @(negedge clk);
    rd_reg(8'd9, d); chk("clr_vs_step", d, 32'h0);
    rd_reg(8'd8, d); chk("ctrl_selfclr", d, 32'h1);

    wr_reg(8'd8, 32'h5);
    step(1'b1);
    rd_reg(8'd9, d); chk("invert", d, 32'hFFFFFFFF);
    wr_reg(8'd8, 32'h1);

`ifdef QUAD_INDEX_EN
    wr_reg(8'd9, 32'd57);
    enc_z = 1'b1; repeat (FL + 4) @(negedge clk);
    enc_z = 1'b0; repeat (FL + 4) @(negedge clk);
    rd_reg(8'd12, d); chk("index57", d, 32'd57);
    rd_reg(8'd11, d); chk("status_idx", {31'b0, d[4]}, 32'h1);
    rd_reg(8'd9, d); chk("idx_keep", d, 32'd57);
    wr_reg(8'd8, 32'h9);
    enc_z = 1'b1; repeat (FL + 4) @(negedge clk);
    enc_z = 1'b0; repeat (FL + 4) @(negedge clk);
    rd_reg(8'd9, d); chk("idx_clr", d, 32'h0);
`endif

    hs1 = 1'b1; rw = 1'b0; addr = 8'd9;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_abort", {31'b0, hs2 === 1'b1}, 32'h0);
    hs1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd_reg(8'd8, d); chk("ctrl_after_rst", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/quad_encoder_slave.md
Name: quad_encoder_slave

Overview:
- Bus slave on the internal 32-bit IO_bus, downstream of the microcontroller-to-bus master. Responds to four-phase register transactions.
- Decodes one quadrature encoder channel (A/B) into a 32-bit position count and a per-period velocity value.
- Exposes control, count, velocity and status registers to the controlling microcontroller.

Parameters:
- REG_BASE, 8: first register address. The block owns REG_BASE..REG_BASE+4.
- FILTER_LEN, 4: consecutive identical samples required before a synchronised A/B level is accepted. Range 1..15.
- VEL_PERIOD, 50000: clk cycles per velocity sample window.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- bus.handshake1_1  input  1  master strobe
- bus.handshake1_2  output  1  slave acknowledge; 1'bz when not selected
- bus.RW  input  1  1 = write, 0 = read
- bus.reg_address  input  8  register address
- bus.data_out  input  32  write data from master
- bus.data_in  output  32  read data to master; 32'hz when not selected
- enc_a  input  1  encoder phase A, asynchronous
- enc_b  input  1  encoder phase B, asynchronous

Behaviour:
- Reset (asynchronous, active-high): all registers, counters and filters go to 0; FSM goes to S_IDLE; handshake1_2 and data_in are released (z).
- Input conditioning:
  - enc_a and enc_b each pass through a 2-flop synchroniser, then a filter.
  - A new filtered level is accepted after FILTER_LEN consecutive equal synchronised samples.
- Decode (4x) runs only when CONTROL[0] = 1:
  - One filtered bit changes: count +1 or -1 by Gray sequence.
  - 00->01->11->10 is +1.
  - CONTROL[2] = 1 inverts the direction.
- Illegal transition (both filtered bits change in the same cycle): count unchanged; STATUS[3] set (sticky).
- Count arithmetic: 32-bit modular. 32'hFFFFFFFF + 1 = 0; 0 - 1 = 32'hFFFFFFFF.
- Velocity:
  - A free-running period counter counts 0..VEL_PERIOD-1 and runs regardless of enable.
  - At wrap: VELOCITY <= count - last_count (32-bit two's complement, modular); last_count <= count.
- Registers (offset from REG_BASE):
  - 0 CONTROL (R/W): bit0 enable, bit2 invert. bit1 clear is self-clearing and always reads 0.
  - 1 COUNT (R/W): a write presets count; last_count is unchanged.
  - 2 VELOCITY (R).
  - 3 STATUS (R): bit0 filtered A, bit1 filtered B, bit2 last direction (1 = up), bit3 error. A read clears bit3 in the same cycle the data is captured.
  - 4 INDEX: see Optional Feature.
  - Writes to read-only registers are acknowledged and ignored.
- Priority when events coincide in the same cycle: CONTROL[1] clear > COUNT write > encoder step.
  - A clear zeroes both count and last_count.
  - An error event coinciding with a STATUS read leaves bit3 = 1.
- Bus FSM, states S_IDLE, S_ACCESS, S_ACK:
  - S_IDLE: when handshake1_1 = 1 and reg_address is in range, go to S_ACCESS. Out-of-range addresses are ignored (stay in S_IDLE, outputs z).
  - S_ACCESS (one cycle): perform the write, or register the read data into the data_in holding register; go to S_ACK.
  - S_ACK: drive handshake1_2 = 1 and data_in = held value. When handshake1_1 is sampled 0, go to S_IDLE; handshake1_2 is released on the next cycle.
  - Latency: handshake1_2 rises 2 cycles after the strobe is first sampled high.
  - bus.RW, reg_address and data_out are sampled in S_ACCESS only.
  - Read data is stable from S_ACK entry until release.
- Reset during a transaction: abort immediately, release the bus, return to S_IDLE.

Optional Feature:
- Macro: QUAD_INDEX_EN.
- Defined:
  - Adds input enc_z (1 bit), with the same synchroniser and filter as A/B.
  - A filtered rising edge of enc_z latches count into INDEX (reg 4, read-only) and sets STATUS[4] (sticky, cleared on STATUS read).
  - If CONTROL[3] = 1, the same edge also zeroes count. This clear ranks below the CONTROL[1] clear and above a COUNT write.
- Undefined:
  - No enc_z port.
  - Reg 4 reads 0; STATUS[4] and CONTROL[3] read 0.
  - Reg 4 is still acknowledged.

Decomposition:
- Package types gains:
  - qe_reg_t enum of register offsets (QE_CONTROL=0 .. QE_INDEX=4).
  - CONTROL/STATUS bit-index constants.
  - bus_fsm_state_t enum.
  - READ_CMD / WRITE_CMD values for RW.
- Sub-module input_filter (synchroniser plus FILTER_LEN filter, parameterised), instantiated 2 or 3 times.

Test Plan:
- Reset, then read reg 1: handshake1_2 rises 2 cycles after strobe; data_in = 32'h0; all outputs z after release.
- Enable. Drive 8 forward Gray steps, each level held ≥ FILTER_LEN+3 cycles: COUNT = 8. Then 10 reverse steps: COUNT = 32'hFFFFFFFE.
- Write COUNT = 32'hFFFFFFFF, then one forward step: COUNT = 0. Glitch on A shorter than FILTER_LEN cycles: no count change.
- Force A and B to toggle together: COUNT unchanged; STATUS reads 32'h8 plus the level bits; a second STATUS read shows bit3 = 0.
- 100 forward steps within one VEL_PERIOD window: VELOCITY = 100 at the next wrap. 30 reverse steps in the following window: VELOCITY = 32'hFFFFFFE2.
- Write CONTROL = 32'h3 coincident with an encoder step: COUNT = 0. With QUAD_INDEX_EN, a Z pulse at count 57 gives INDEX = 57.
